// File: rtl/if_map_load_ctrl.sv
// if_map_load_ctrl
// Loads one KxK convolution window into the 8x8 IF-map register buffer.
// Row reads are issued to the 8-bank IF-map memory. One cycle later the
// matching per-register load strobes are driven. Lane selects and
// local-reset vectors are also produced here.
// Build option: define IFMAP_CTRL_WIN_COUNT_EN to enable the completed-window
// counter on win_count. When it is not defined, win_count is tied to zero.
module if_map_load_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int ROW_STRIDE_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              kernel_size,
  input  logic [2:0]              col_shift,
  input  logic [ADDR_W-1:0]       row_base,
  input  logic [ROW_STRIDE_W-1:0] row_stride,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic [63:0]             Reg_loads,
  output logic [191:0]            Mux_Sel,
  output logic [63:0]             Local_Reset,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             win_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Map kernel_size to an effective K: 0 and values above 8 behave as 8.
  function automatic logic [3:0] clamp_k(input logic [3:0] ks);
    logic [3:0] k;
    if ((ks == 4'd0) || (ks > 4'd8)) begin
      k = 4'd8;
    end else begin
      k = ks;
    end
    return k;
  endfunction

  // Registers outside the KxK window (row >= K or col >= K).
  function automatic logic [63:0] unused_mask(input logic [3:0] k);
    logic [63:0] m;
    m = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        m[8*r+c] = (r >= int'(k)) || (c >= int'(k));
      end
    end
    return m;
  endfunction

  // Columns 0..K-1 of a single buffer row.
  function automatic logic [7:0] row_bits(input logic [3:0] k);
    logic [7:0] m;
    m = 8'd0;
    for (int c = 0; c < 8; c++) begin
      m[c] = (c < int'(k));
    end
    return m;
  endfunction

  // Lane select for every register: (col + col_shift) mod 8. It is the same in every row.
  function automatic logic [191:0] lane_sel(input logic [2:0] cs);
    logic [191:0] m;
    m = 192'd0;
    for (int i = 0; i < 64; i++) begin
      m[3*i +: 3] = 3'((i % 8) + int'(cs));
    end
    return m;
  endfunction

  // FSM state and latched window configuration
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_k;
  logic [ROW_STRIDE_W-1:0] r_stride;
  // r_rd_cnt counts reads already issued. r_ld_cnt counts row loads already issued.
  logic [3:0]              r_rd_cnt;
  logic [3:0]              r_ld_cnt;

  // Registered outputs and their next values
  logic                    r_rd_en,       w_rd_en;
  logic [ADDR_W-1:0]       r_rd_addr,     w_rd_addr;
  logic [63:0]             r_reg_loads,   w_reg_loads;
  logic [191:0]            r_mux_sel,     w_mux_sel;
  logic [63:0]             r_local_reset, w_local_reset;
  logic                    r_busy,        w_busy;
  logic                    r_done,        w_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave FILL once all K row loads have been issued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (r_ld_cnt == r_k) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-value logic. Read 0 is issued on the same edge that accepts start,
  // so all outputs come straight from flops without added latency.
  always_comb begin
    w_rd_en       = 1'b0;
    w_rd_addr     = r_rd_addr;
    w_reg_loads   = 64'd0;
    w_mux_sel     = r_mux_sel;
    w_local_reset = 64'd0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rd_en       = 1'b1;
          w_rd_addr     = row_base;
          w_mux_sel     = lane_sel(col_shift);
          w_local_reset = unused_mask(clamp_k(kernel_size));
          w_busy        = 1'b1;
        end else begin
          w_busy        = 1'b0;
        end
      end
      S_FILL: begin
        w_busy = 1'b1;
        if (r_rd_cnt < r_k) begin
          w_rd_en   = 1'b1;
          w_rd_addr = ADDR_W'(r_rd_addr + ADDR_W'(r_stride));
        end else begin
          w_rd_en   = 1'b0;
        end
        if (r_ld_cnt < r_k) begin
          w_reg_loads = {56'd0, row_bits(r_k)} << {r_ld_cnt[2:0], 3'b000};
        end else begin
          w_done      = 1'b1;
        end
      end
      S_DONE: begin
        w_busy = 1'b0;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Window configuration latch and read/load counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k      <= 4'd0;
      r_stride <= '0;
      r_rd_cnt <= 4'd0;
      r_ld_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k      <= clamp_k(kernel_size);
            r_stride <= row_stride;
            r_rd_cnt <= 4'd1;
            r_ld_cnt <= 4'd0;
          end
        end
        S_FILL: begin
          if (r_rd_cnt < r_k) begin
            r_rd_cnt <= r_rd_cnt + 4'd1;
          end
          if (r_ld_cnt < r_k) begin
            r_ld_cnt <= r_ld_cnt + 4'd1;
          end
        end
        default: begin
          r_rd_cnt <= r_rd_cnt;
          r_ld_cnt <= r_ld_cnt;
        end
      endcase
    end
  end

  // Output registers. Mux_Sel holds between windows and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_reg_loads   <= 64'd0;
      r_mux_sel     <= 192'd0;
      r_local_reset <= 64'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_rd_en       <= w_rd_en;
      r_rd_addr     <= w_rd_addr;
      r_reg_loads   <= w_reg_loads;
      r_mux_sel     <= w_mux_sel;
      r_local_reset <= w_local_reset;
      r_busy        <= w_busy;
      r_done        <= w_done;
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign Reg_loads   = r_reg_loads;
  assign Mux_Sel     = r_mux_sel;
  assign Local_Reset = r_local_reset;
  assign busy        = r_busy;
  assign done        = r_done;

`ifdef IFMAP_CTRL_WIN_COUNT_EN
  logic [15:0] r_win_count;

  // Completed-window counter. It steps on the edge that raises done and wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_count <= 16'd0;
    end else if (w_done) begin
      r_win_count <= r_win_count + 16'd1;
    end else begin
      r_win_count <= r_win_count;
    end
  end

  assign win_count = r_win_count;
`else
  assign win_count = 16'd0;
`endif

endmodule

// File: tb/tb_if_map_load_ctrl.sv
// Scoreboard bench for if_map_load_ctrl. The driver pushes the expected read,
// load, local-reset and done events with their cycle numbers. A negedge
// monitor pops an entry whenever the DUT shows that kind of event and compares it.
module tb_if_map_load_ctrl;

  localparam int ADDR_W = 10;
  localparam int RS_W   = 10;
  localparam logic [191:0] MUX_CS0 = {8{24'hFAC688}};
  localparam logic [191:0] MUX_CS5 = {8{24'h8D11F5}};

  logic              clk;
  logic              reset;
  logic              start;
  logic [3:0]        kernel_size;
  logic [2:0]        col_shift;
  logic [ADDR_W-1:0] row_base;
  logic [RS_W-1:0]   row_stride;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       Reg_loads;
  logic [191:0]      Mux_Sel;
  logic [63:0]       Local_Reset;
  logic              busy;
  logic              done;
  logic [15:0]       win_count;

  if_map_load_ctrl #(.ADDR_W(ADDR_W), .ROW_STRIDE_W(RS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel_size(kernel_size),
    .col_shift(col_shift), .row_base(row_base), .row_stride(row_stride),
    .rd_en(rd_en), .rd_addr(rd_addr), .Reg_loads(Reg_loads), .Mux_Sel(Mux_Sel),
    .Local_Reset(Local_Reset), .busy(busy), .done(done), .win_count(win_count)
  );

  typedef struct { int cyc; logic [63:0] val; } ev_t;
  typedef struct { int cyc; logic [191:0] mux; logic [15:0] wc; } dn_t;

  ev_t rd_q[$];
  ev_t ld_q[$];
  ev_t lr_q[$];
  dn_t dn_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] exp_win  = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: every output event must match the oldest entry of its kind
  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    if (rd_en === 1'b1) begin
      if (rd_q.size() == 0) unexpected("rd_en");
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", 192'(cyc), 192'(e.cyc));
        chk("rd_addr", 192'(rd_addr), 192'(e.val));
      end
    end
    if ((Reg_loads !== 64'd0) && (Reg_loads !== 64'bx)) begin
      if (ld_q.size() == 0) unexpected("Reg_loads");
      else begin
        e = ld_q.pop_front();
        chk("ld_cycle", 192'(cyc), 192'(e.cyc));
        chk("Reg_loads", 192'(Reg_loads), 192'(e.val));
      end
    end
    if ((Local_Reset !== 64'd0) && (Local_Reset !== 64'bx)) begin
      if (lr_q.size() == 0) unexpected("Local_Reset");
      else begin
        e = lr_q.pop_front();
        chk("lr_cycle", 192'(cyc), 192'(e.cyc));
        chk("Local_Reset", 192'(Local_Reset), 192'(e.val));
      end
    end
    if (done === 1'b1) begin
      if (dn_q.size() == 0) unexpected("done");
      else begin
        d = dn_q.pop_front();
        chk("done_cycle", 192'(cyc), 192'(d.cyc));
        chk("Mux_Sel", Mux_Sel, d.mux);
        chk("win_count", 192'(win_count), 192'(d.wc));
        chk("busy_in_done", 192'(busy), 192'(1'b1));
      end
    end
  end

  // Expected events of a K-window started in cycle t0, limited to nrd reads and nld loads
  task automatic push_window(input int k, input int nrd, input int nld,
                             input logic [9:0] base, input logic [9:0] stride,
                             input logic [191:0] mux, input int t0, input bit with_done);
    logic [63:0] rowm;
    logic [63:0] win;
    logic [9:0]  a;
    win = 64'd0;
    for (int r = 0; r < k; r++) begin
      rowm = ((64'd1 << k) - 64'd1) << (8 * r);
      win  = win | rowm;
      a    = 10'(base + 10'(r) * stride);
      if (r < nrd) rd_q.push_back('{cyc: t0 + 1 + r, val: 64'(a)});
      if (r < nld) ld_q.push_back('{cyc: t0 + 2 + r, val: rowm});
    end
    if (k < 8) lr_q.push_back('{cyc: t0 + 1, val: ~win});
    if (with_done) begin
`ifdef IFMAP_CTRL_WIN_COUNT_EN
      exp_win = exp_win + 16'd1;
`endif
      dn_q.push_back('{cyc: t0 + k + 2, mux: mux, wc: exp_win});
    end
  endtask

  // Raise start with a configuration at the current negedge
  task automatic drive_start(input logic [3:0] ks, input logic [2:0] cs,
                             input logic [9:0] base, input logic [9:0] stride,
                             output int t0);
    kernel_size = ks;
    col_shift   = cs;
    row_base    = base;
    row_stride  = stride;
    start       = 1'b1;
    t0          = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},       192'(rd_en),       192'(1'b0));
    chk({tag, "_rd_addr"},     192'(rd_addr),     192'(10'd0));
    chk({tag, "_Reg_loads"},   192'(Reg_loads),   192'(64'd0));
    chk({tag, "_Mux_Sel"},     Mux_Sel,           192'd0);
    chk({tag, "_Local_Reset"}, 192'(Local_Reset), 192'(64'd0));
    chk({tag, "_busy"},        192'(busy),        192'(1'b0));
    chk({tag, "_done"},        192'(done),        192'(1'b0));
    chk({tag, "_win_count"},   192'(win_count),   192'(16'd0));
  endtask

  // Run one complete window: push expectations, drop start, then wait past done
  task automatic run_window(input logic [3:0] ks, input int k, input logic [2:0] cs,
                            input logic [9:0] base, input logic [9:0] stride,
                            input logic [191:0] mux);
    int t0;
    @(negedge clk);
    chk("busy_idle", 192'(busy), 192'(1'b0));
    drive_start(ks, cs, base, stride, t0);
    push_window(k, k, k, base, stride, mux, t0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (k + 3) @(negedge clk);
  endtask

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; kernel_size = 4'd0; col_shift = 3'd0;
    row_base = 10'd0; row_stride = 10'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // K=3 with hand-written expected events
    @(negedge clk);
    drive_start(4'd3, 3'd0, 10'h010, 10'h020, t0);
    rd_q.push_back('{cyc: t0 + 1, val: 64'h010});
    rd_q.push_back('{cyc: t0 + 2, val: 64'h030});
    rd_q.push_back('{cyc: t0 + 3, val: 64'h050});
    ld_q.push_back('{cyc: t0 + 2, val: 64'h7});
    ld_q.push_back('{cyc: t0 + 3, val: 64'h700});
    ld_q.push_back('{cyc: t0 + 4, val: 64'h70000});
    lr_q.push_back('{cyc: t0 + 1, val: 64'hFFFF_FFFF_FFF8_F8F8});
`ifdef IFMAP_CTRL_WIN_COUNT_EN
    exp_win = exp_win + 16'd1;
`endif
    dn_q.push_back('{cyc: t0 + 5, mux: MUX_CS0, wc: exp_win});
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mux_hold_idle", Mux_Sel, MUX_CS0);

    // K=8 with col_shift=5: no local reset, rotated lanes
    run_window(4'd8, 8, 3'd5, 10'h000, 10'h001, MUX_CS5);
    // kernel_size=0 behaves as K=8
    run_window(4'd0, 8, 3'd0, 10'h123, 10'h011, MUX_CS0);
    // kernel_size=1: single read, single load
    run_window(4'd1, 1, 3'd5, 10'h200, 10'h040, MUX_CS5);
    // Address wrap-around
    run_window(4'd4, 4, 3'd0, 10'h3F0, 10'h008, MUX_CS0);

    // A second start during FILL is ignored; a start right after done is accepted
    @(negedge clk);
    drive_start(4'd4, 3'd0, 10'h100, 10'h004, t0);
    push_window(4, 4, 4, 10'h100, 10'h004, MUX_CS0, t0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    kernel_size = 4'd2; col_shift = 3'd5; row_base = 10'h2AA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 7) @(negedge clk);
    chk("busy_after_done", 192'(busy), 192'(1'b0));
    drive_start(4'd9, 3'd5, 10'h050, 10'h002, t0);
    push_window(8, 8, 8, 10'h050, 10'h002, MUX_CS5, t0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);

    // Reset during cycle 3 of a K=5 window abandons it without done
    drive_start(4'd5, 3'd5, 10'h040, 10'h010, t0);
    push_window(5, 3, 2, 10'h040, 10'h010, MUX_CS5, t0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset   = 1'b0;
    exp_win = 16'd0;
    repeat (8) @(negedge clk);
    run_window(4'd3, 3, 3'd0, 10'h001, 10'h100, MUX_CS0);

    chk("rd_q_drained", 192'(rd_q.size()), 192'd0);
    chk("ld_q_drained", 192'(ld_q.size()), 192'd0);
    chk("lr_q_drained", 192'(lr_q.size()), 192'd0);
    chk("dn_q_drained", 192'(dn_q.size()), 192'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_map_load_ctrl.md
# if_map_load_ctrl

Sequencer for the 64-register IF-map buffer, organised as an 8×8 grid of 16-bit registers. It loads one K×K convolution window into the buffer by issuing row reads to the 8-bank IF-map memory, then drives the buffer's per-register load, 3-bit lane-select and local-reset vectors. It sits between the convolution top-level control (start/done handshake) and the IF-map buffer and memory.

## Interface
Parameters:
- ADDR_W, 10, IF-map memory row-address width
- ROW_STRIDE_W, 10, width of the row-stride input

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to load a window; sampled only in IDLE
- kernel_size  in  4  K; 1..8 valid, 0 and 9..15 clamp to 8; latched at start
- col_shift  in  3  bank rotation of window column 0; latched at start
- row_base  in  ADDR_W  memory address of window row 0; latched at start
- row_stride  in  ROW_STRIDE_W  address increment between window rows; latched at start
- rd_en  out  1  memory read strobe; data returns exactly 1 cycle later on the 8 lanes
- rd_addr  out  ADDR_W  row address for rd_en
- Reg_loads  out  64  per-register load enable; bit i = register i = 8·row + col
- Mux_Sel  out  192  lane select; bits [3i+2:3i] belong to register i
- Local_Reset  out  64  clears unused registers
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the window is complete
- win_count  out  16  completed-window counter (see Configuration)

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: all strobes are 0. On start, latch the configuration inputs, clear the internal counters rd_cnt and ld_cnt, and go to FILL.
- FILL, read side: for rd_cnt = 0..K-1, assert rd_en with rd_addr = row_base + rd_cnt·row_stride, truncated modulo 2^ADDR_W (wrap-around is legal).
- FILL, load side: one cycle after each read, assert Reg_loads bits 8·ld_cnt + c for c = 0..K-1 only.
- FILL, first cycle: assert Local_Reset for every register with row ≥ K or col ≥ K, for that one cycle only. When K = 8, no Local_Reset bit is asserted.
- Mux_Sel for register (r,c) = (c + col_shift) mod 8. It is registered from the latched col_shift, constant for the whole operation, and independent of r.
- Leave FILL after the last load (ld_cnt = K-1) and enter DONE. DONE lasts one cycle, pulses done, then returns to IDLE.
- Mux_Sel holds its last value in IDLE so that buffer contents stay addressable.
- start during FILL or DONE is ignored; no queuing.
- Reset at any point forces IDLE at the next edge. Every output then goes to 0, including Mux_Sel and win_count. Registers already loaded are left as they are; any partial window is abandoned with no done pulse.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..K: rd_en high with rows 0..K-1. Local_Reset is high in cycle 1 only.
- Cycles 2..K+1: Reg_loads for rows 0..K-1.
- Cycle K+2: DONE; done = 1 and busy = 1.
- Cycle K+3: IDLE. The earliest accepted next start is in cycle K+3.
- Total latency from start to done: K+2 cycles. Throughput: one window per K+3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: rd_en = 0, rd_addr = 0, Reg_loads = 0, Mux_Sel = 0, Local_Reset = 0, busy = 0, done = 0, win_count = 0.

## Configuration
- Macro: IFMAP_CTRL_WIN_COUNT_EN.
- Defined: win_count increments by 1, wrapping at 16 bits, in the cycle done is high. It clears only on reset.
- Undefined: win_count is tied to 0 and no counter flops are synthesised. The port is present in both builds.

## Test plan
- K=3, col_shift=0, row_base=0x010, row_stride=0x020, start → rd_addr 0x010, 0x030, 0x050 in cycles 1–3. Reg_loads = 0x7, 0x700, 0x70000 in cycles 2–4. Local_Reset = 0xFFFF_FFFF_FFF8_F8F8 in cycle 1. done in cycle 5.
- K=8, col_shift=5 → Local_Reset never asserted. Mux_Sel fields for cols 0..7 = 5,6,7,0,1,2,3,4 in every row. 8 loads of 0xFF<<8r. done in cycle 10.
- kernel_size=0 → behaves exactly as K=8. kernel_size=1 → single read, Reg_loads = 0x1, done in cycle 3.
- row_base=0x3F0, row_stride=0x008, K=4, ADDR_W=10 → rd_addr 0x3F0, 0x3F8, 0x000, 0x008 (wrap).
- start pulsed again in cycle 2 of a K=4 run → ignored; exactly one done, in cycle 6. A start in the cycle after done is accepted.
- reset asserted in cycle 3 of a K=5 run → all outputs 0 at the next edge, no done pulse. With IFMAP_CTRL_WIN_COUNT_EN defined, win_count = 0. A subsequent start completes normally and win_count = 1.
